// File: rtl/seg7_scan_driver_if.sv
// Host-side bus of seg7_scan_driver: value/dp load strobe with
// busy and commit-acknowledge status back to the host.
interface seg7_scan_driver_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        busy;
    logic        load_ack;

    modport master (
        output value, dp_in, load,
        input  busy, load_ack
    );

    modport slave (
        input  value, dp_in, load,
        output busy, load_ack
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed seven-segment driver with anode blanking and
// frame-boundary commits. Option: LEADING_ZERO_BLANK_EN.
module seg7_scan_driver #(
    parameter int BLANK_CYCLES = 120,
    parameter int BLANK_W      = 8
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic [1:0]          ref_clk,
    seg7_scan_driver_if.slave   host,
    output logic [3:0]          an,
    output logic [6:0]          seg,
    output logic                dp
);

    typedef enum logic [1:0] {WAIT, BLANK, DRIVE} state_t;

    state_t               state;
    logic [BLANK_W-1:0]   cnt;
    logic [1:0]           ref_q;
    logic [15:0]          disp_val;
    logic [3:0]           disp_dp;
    logic [15:0]          pend_val;
    logic [3:0]           pend_dp;
    logic                 busy_q;

    logic                 change;
    logic                 commit;
    logic [15:0]          nx_val;
    logic [3:0]           nx_dp;
    logic [3:0]           nib;
    logic                 show;
    logic [3:0]           drv_an;
    logic [6:0]           drv_seg;
    logic                 drv_dp;

    assign change = (ref_clk != ref_q);
    assign commit = change && (ref_clk == 2'd0) && busy_q;

    assign host.busy     = busy_q;
    assign host.load_ack = commit;

    // Display contents as they will be after this edge, so a drive
    // registered on the commit edge already uses the new frame.
    assign nx_val = commit ? pend_val : disp_val;
    assign nx_dp  = commit ? pend_dp  : disp_dp;
    assign nib    = nx_val[{ref_clk, 2'b00} +: 4];

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [1:0] msd;

    // Index of the most-significant nonzero nibble; digit 0 always shown.
    always_comb begin
        msd = 2'd0;
        if (nx_val[7:4]   != 4'h0) msd = 2'd1;
        if (nx_val[11:8]  != 4'h0) msd = 2'd2;
        if (nx_val[15:12] != 4'h0) msd = 2'd3;
    end

    assign show = (ref_clk <= msd);
`else
    assign show = 1'b1;
`endif

    // Ref index is used directly: it equals ref_q unless a change is
    // being taken this cycle, in which case the newest index wins.
    assign drv_an  = show ? ~(4'b0001 << ref_clk) : 4'b1111;
    assign drv_seg = show ? hex7(nib) : 7'h7F;
    assign drv_dp  = show ? ~nx_dp[ref_clk] : 1'b1;

    // Digit-index edge detector.
    always_ff @(posedge sysclk) begin
        if (reset) ref_q <= 2'd0;
        else       ref_q <= ref_clk;
    end

    // Pending/display registers and the load/commit handshake.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            disp_val <= '0;
            disp_dp  <= '0;
            pend_val <= '0;
            pend_dp  <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (commit) begin
                disp_val <= pend_val;
                disp_dp  <= pend_dp;
            end
            if (host.load) begin
                pend_val <= host.value;
                pend_dp  <= host.dp_in;
                busy_q   <= 1'b1;
            end else if (commit) begin
                busy_q   <= 1'b0;
            end
        end
    end

    // Scan FSM with registered anode/segment outputs.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= WAIT;
            cnt   <= '0;
            an    <= 4'b1111;
            seg   <= 7'h7F;
            dp    <= 1'b1;
        end else if (change) begin
            if (BLANK_CYCLES == 0) begin
                state <= DRIVE;
                an    <= drv_an;
                seg   <= drv_seg;
                dp    <= drv_dp;
            end else begin
                state <= BLANK;
                cnt   <= BLANK_W'(BLANK_CYCLES - 1);
                an    <= 4'b1111;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end
        end else begin
            unique case (state)
                BLANK: begin
                    if (cnt == '0) begin
                        state <= DRIVE;
                        an    <= drv_an;
                        seg   <= drv_seg;
                        dp    <= drv_dp;
                    end else begin
                        cnt   <= cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    an  <= drv_an;
                    seg <= drv_seg;
                    dp  <= drv_dp;
                end
                default: begin
                    state <= WAIT;
                    an    <= 4'b1111;
                    seg   <= 7'h7F;
                    dp    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: blanked instance (120) and a
// zero-blank instance driven from the same stimulus.
module tb_seg7_scan_driver;

    localparam int BLANK = 120;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] SF = 7'b0001110;

    typedef struct {
        logic [1:0]  idx;
        logic [1:0]  ld;
        logic [15:0] val;
        logic [3:0]  dpi;
        logic        ack;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        busy;
    } vec_t;

    logic        sysclk = 1'b0;
    logic        reset;
    logic [1:0]  ref_clk;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic [3:0]  an0, an1;
    logic [6:0]  seg0, seg1;
    logic        dp0, dp1;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t sb[$];
    vec_t tbl[29];

    seg7_scan_driver_if bus0 ();
    seg7_scan_driver_if bus1 ();

    assign bus0.value = value;
    assign bus0.dp_in = dp_in;
    assign bus0.load  = load;
    assign bus1.value = value;
    assign bus1.dp_in = dp_in;
    assign bus1.load  = load;

    seg7_scan_driver #(.BLANK_CYCLES(BLANK), .BLANK_W(8)) u_dut (
        .sysclk (sysclk),
        .reset  (reset),
        .ref_clk(ref_clk),
        .host   (bus0.slave),
        .an     (an0),
        .seg    (seg0),
        .dp     (dp0)
    );

    seg7_scan_driver #(.BLANK_CYCLES(0), .BLANK_W(8)) u_dut0 (
        .sysclk (sysclk),
        .reset  (reset),
        .ref_clk(ref_clk),
        .host   (bus1.slave),
        .an     (an1),
        .seg    (seg1),
        .dp     (dp1)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [1:0] idx, input logic [1:0] ld,
        input logic [15:0] val, input logic [3:0] dpi,
        input logic ack, input logic [3:0] an_e,
        input logic [6:0] seg_e, input logic dp_e, input logic busy_e);
        vec_t v;
        v.idx = idx; v.ld = ld; v.val = val; v.dpi = dpi;
        v.ack = ack; v.an = an_e; v.seg = seg_e; v.dp = dp_e;
        v.busy = busy_e;
        return v;
    endfunction

    task automatic apply_vec(input vec_t v, input int n);
        vec_t e;
        @(posedge sysclk); #1;
        if (v.ld == 2'd1) begin
            value = v.val; dp_in = v.dpi; load = 1'b1;
            @(posedge sysclk); #1;
            load = 1'b0;
        end
        if (v.ld == 2'd2) begin
            value = v.val; dp_in = v.dpi; load = 1'b1;
        end
        ref_clk = v.idx;
        sb.push_back(v);
        @(negedge sysclk);
        chk($sformatf("v%0d ack", n), 32'(bus0.load_ack), 32'(v.ack));
        @(posedge sysclk); #1;
        load = 1'b0;
        @(negedge sysclk);
        chk($sformatf("v%0d ack_pulse", n), 32'(bus0.load_ack), 32'(0));
        chk($sformatf("v%0d blank_start", n), 32'(an0), 32'hF);
        chk($sformatf("v%0d nb_an", n), 32'(an1), 32'(v.an));
        chk($sformatf("v%0d nb_dp", n), 32'(dp1), 32'(v.dp));
        repeat (BLANK - 1) @(posedge sysclk);
        @(negedge sysclk);
        chk($sformatf("v%0d blank_end", n), 32'(an0), 32'hF);
        @(posedge sysclk);
        @(negedge sysclk);
        if (sb.size() == 0) begin
            chk($sformatf("v%0d sb_empty", n), 32'(0), 32'(1));
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d an", n), 32'(an0), 32'(e.an));
            if (e.an != 4'hF)
                chk($sformatf("v%0d seg", n), 32'(seg0), 32'(e.seg));
            chk($sformatf("v%0d dp", n), 32'(dp0), 32'(e.dp));
            chk($sformatf("v%0d busy", n), 32'(bus0.busy), 32'(e.busy));
        end
    endtask

    initial begin
        tbl[0]  = mk(1, 0, 0, 0, 0, LZB ? 4'hF : 4'b1101, S0, 1, 0);
        tbl[1]  = mk(2, 0, 0, 0, 0, LZB ? 4'hF : 4'b1011, S0, 1, 0);
        tbl[2]  = mk(3, 0, 0, 0, 0, LZB ? 4'hF : 4'b0111, S0, 1, 0);
        tbl[3]  = mk(0, 1, 16'h1234, 4'b0101, 1, 4'b1110, S4, 0, 0);
        tbl[4]  = mk(1, 0, 0, 0, 0, 4'b1101, S3, 1, 0);
        tbl[5]  = mk(2, 0, 0, 0, 0, 4'b1011, S2, 0, 0);
        tbl[6]  = mk(3, 0, 0, 0, 0, 4'b0111, S1, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 4'b1110, S4, 0, 0);
        tbl[8]  = mk(3, 0, 0, 0, 0, 4'b0111, S1, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 1, 4'b1110, S0, 1, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 4'b1101, SF, 1, 0);
        tbl[11] = mk(2, 0, 0, 0, 0, LZB ? 4'hF : 4'b1011, S0, 1, 0);
        tbl[12] = mk(3, 0, 0, 0, 0, LZB ? 4'hF : 4'b0111, S0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 4'b1110, S0, 1, 0);
        tbl[14] = mk(1, 1, 16'h1111, 4'b0000, 0, 4'b1101, SF, 1, 1);
        tbl[15] = mk(2, 0, 0, 0, 0, LZB ? 4'hF : 4'b1011, S0, 1, 1);
        tbl[16] = mk(3, 0, 0, 0, 0, LZB ? 4'hF : 4'b0111, S0, 1, 1);
        tbl[17] = mk(0, 2, 16'h0050, 4'b0000, 1, 4'b1110, S1, 1, 1);
        tbl[18] = mk(1, 0, 0, 0, 0, 4'b1101, S1, 1, 1);
        tbl[19] = mk(2, 0, 0, 0, 0, 4'b1011, S1, 1, 1);
        tbl[20] = mk(3, 0, 0, 0, 0, 4'b0111, S1, 1, 1);
        tbl[21] = mk(0, 0, 0, 0, 1, 4'b1110, S0, 1, 0);
        tbl[22] = mk(1, 0, 0, 0, 0, 4'b1101, S5, 1, 0);
        tbl[23] = mk(2, 0, 0, 0, 0, LZB ? 4'hF : 4'b1011, S0, 1, 0);
        tbl[24] = mk(3, 0, 0, 0, 0, LZB ? 4'hF : 4'b0111, S0, 1, 0);
        tbl[25] = mk(1, 0, 0, 0, 0, LZB ? 4'hF : 4'b1101, S0, 1, 0);
        tbl[26] = mk(2, 0, 0, 0, 0, LZB ? 4'hF : 4'b1011, S0, 1, 0);
        tbl[27] = mk(3, 0, 0, 0, 0, LZB ? 4'hF : 4'b0111, S0, 1, 0);
        tbl[28] = mk(0, 0, 0, 0, 0, 4'b1110, S0, 1, 0);

        reset = 1'b1; ref_clk = 2'd0;
        value = '0; dp_in = '0; load = 1'b0;
        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst an", 32'(an0), 32'hF);
        chk("rst seg", 32'(seg0), 32'h7F);
        chk("rst dp", 32'(dp0), 32'(1));
        chk("rst busy", 32'(bus0.busy), 32'(0));
        chk("rst ack", 32'(bus0.load_ack), 32'(0));
        @(posedge sysclk); #1;
        reset = 1'b0;
        repeat (5) @(posedge sysclk);
        @(negedge sysclk);
        chk("wait an", 32'(an0), 32'hF);

        for (int i = 0; i < 8; i++) apply_vec(tbl[i], i);

        // Change during blanking restarts the counter on the newest index.
        @(posedge sysclk); #1;
        ref_clk = 2'd1;
        repeat (50) @(posedge sysclk);
        #1 ref_clk = 2'd2;
        repeat (71) @(posedge sysclk);
        @(negedge sysclk);
        chk("restart old_slot", 32'(an0), 32'hF);
        repeat (49) @(posedge sysclk);
        @(negedge sysclk);
        chk("restart blank_end", 32'(an0), 32'hF);
        @(posedge sysclk);
        @(negedge sysclk);
        chk("restart an", 32'(an0), 32'(4'b1011));
        chk("restart seg", 32'(seg0), 32'(S2));
        chk("restart dp", 32'(dp0), 32'(0));
        chk("restart nb_an", 32'(an1), 32'(4'b1011));

        // Two loads before the boundary: latest wins, single ack.
        @(posedge sysclk); #1;
        value = 16'hAAAA; dp_in = 4'hF; load = 1'b1;
        @(posedge sysclk); #1;
        value = 16'h00F0; dp_in = 4'h0;
        @(posedge sysclk); #1;
        load = 1'b0;
        @(negedge sysclk);
        chk("dbl busy", 32'(bus0.busy), 32'(1));

        for (int i = 8; i < 25; i++) apply_vec(tbl[i], i);

        // Reset mid-drive discards pending data.
        @(posedge sysclk); #1;
        value = 16'h9999; dp_in = 4'hF; load = 1'b1;
        @(posedge sysclk); #1;
        load = 1'b0;
        @(negedge sysclk);
        chk("pre_rst busy", 32'(bus0.busy), 32'(1));
        @(posedge sysclk); #1;
        reset = 1'b1; ref_clk = 2'd0;
        @(posedge sysclk);
        @(negedge sysclk);
        chk("mid_rst an", 32'(an0), 32'hF);
        chk("mid_rst seg", 32'(seg0), 32'h7F);
        chk("mid_rst dp", 32'(dp0), 32'(1));
        chk("mid_rst busy", 32'(bus0.busy), 32'(0));
        chk("mid_rst nb_an", 32'(an1), 32'hF);
        @(posedge sysclk); #1;
        reset = 1'b0;

        for (int i = 25; i < 29; i++) apply_vec(tbl[i], i);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
